// File: rtl/proc_control_unit_if.sv
// Control bundle between the processor sequencer and its 16-bit datapath.
// The master side is the sequencer, and the slave side is the datapath or switch inputs.
interface proc_control_unit_if #(
    parameter int DATA_W = 16
);
    logic              Run;
    logic [DATA_W-1:0] DIN;
    logic              IRin;
    logic [7:0]        Rin;
    logic [7:0]        Rout;
    logic              DINout;
    logic              Gout;
    logic              Ain;
    logic              Gin;
    logic              AddSub;
    logic              Done;
    logic [1:0]        Step;

    modport master (
        input  Run, DIN,
        output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Step
    );

    modport slave (
        output Run, DIN,
        input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Step
    );
endinterface

// File: rtl/proc_control_unit.sv
// Sequencer for the R0-R7/A/G datapath. It fetches a 9-bit IIIXXXYYY instruction in T0.
// It then drives the register enables, the bus selects, AddSub and Done through T1-T3.
module proc_control_unit #(
    parameter int DATA_W = 16,
    parameter int IR_LSB = 7
) (
    input  logic                  Clock,
    input  logic                  Reset,
    proc_control_unit_if.master   bus
);
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t      step_reg, step_next;
    logic [8:0] ir_reg, ir_next;

    logic [2:0] ir_op, ir_x, ir_y;
    logic [7:0] x_dec, y_dec;

    logic       irin_c, dinout_c, gout_c, ain_c, gin_c, addsub_c, done_c;
    logic [7:0] rin_c, rout_c;

    assign ir_op = ir_reg[8:6];
    assign ir_x  = ir_reg[5:3];
    assign ir_y  = ir_reg[2:0];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign x_dec[gi] = (ir_x == 3'(gi));
            assign y_dec[gi] = (ir_y == 3'(gi));
        end
    endgenerate

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step_reg <= T0;
            ir_reg   <= 9'd0;
        end else begin
            step_reg <= step_next;
            ir_reg   <= ir_next;
        end
    end

    always_comb begin
        step_next = T0;
        ir_next   = ir_reg;
        irin_c    = 1'b0;
        rin_c     = 8'd0;
        rout_c    = 8'd0;
        dinout_c  = 1'b0;
        gout_c    = 1'b0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;

        case (step_reg)
            T0: begin
                irin_c = bus.Run;
                if (bus.Run) begin
                    ir_next   = bus.DIN[IR_LSB+8:IR_LSB];
                    step_next = T1;
                end
            end
            T1: begin
                case (ir_op)
                    3'b000: begin
                        rout_c = y_dec;
                        rin_c  = x_dec;
                        done_c = 1'b1;
                    end
                    3'b001: begin
                        dinout_c = 1'b1;
                        rin_c    = x_dec;
                        done_c   = 1'b1;
                    end
                    3'b010, 3'b011: begin
                        rout_c    = x_dec;
                        ain_c     = 1'b1;
                        step_next = T2;
                    end
                    // Reserved opcodes retire as a NOP.
                    default: done_c = 1'b1;
                endcase
            end
            T2: begin
                rout_c    = y_dec;
                gin_c     = 1'b1;
                addsub_c  = ir_op[0];
                step_next = T3;
            end
            T3: begin
                gout_c = 1'b1;
                rin_c  = x_dec;
                done_c = 1'b1;
            end
            default: step_next = T0;
        endcase
    end

    // Reset masks every output immediately, so an interrupted instruction writes nothing.
    assign bus.IRin   = irin_c   & ~Reset;
    assign bus.Rin    = Reset ? 8'd0 : rin_c;
    assign bus.Rout   = Reset ? 8'd0 : rout_c;
    assign bus.DINout = dinout_c & ~Reset;
    assign bus.Gout   = gout_c   & ~Reset;
    assign bus.Ain    = ain_c    & ~Reset;
    assign bus.Gin    = gin_c    & ~Reset;
    assign bus.AddSub = addsub_c & ~Reset;
    assign bus.Done   = done_c   & ~Reset;
    assign bus.Step   = Reset ? 2'd0 : step_reg;
endmodule

// File: tb/tb_proc_control_unit.sv
// Directed bench for proc_control_unit that checks every output, cycle by cycle.
module tb_proc_control_unit;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    proc_control_unit_if #(.DATA_W(16)) bus ();

    proc_control_unit #(.DATA_W(16), .IR_LSB(7)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Field order is {Rin, Rout, IRin, DINout, Gout, Ain, Gin, AddSub, Done, Step}.
    function automatic logic [31:0] ew(input logic [7:0] rin, input logic [7:0] rout,
                                       input logic irin, input logic dinout, input logic gout,
                                       input logic ain, input logic gin, input logic addsub,
                                       input logic done, input logic [1:0] step);
        return {7'd0, rin, rout, irin, dinout, gout, ain, gin, addsub, done, step};
    endfunction

    function automatic logic [15:0] din_of(input logic [8:0] ir);
        return {ir, 7'd0};
    endfunction

    task automatic cyc(input string tag, input logic rst, input logic run,
                       input logic [15:0] din, input logic [31:0] exp);
        logic [31:0] obs;
        int          drivers;
        @(negedge Clock);
        Reset   = rst;
        bus.Run = run;
        bus.DIN = din;
        #1;
        obs = {7'd0, bus.Rin, bus.Rout, bus.IRin, bus.DINout, bus.Gout, bus.Ain,
               bus.Gin, bus.AddSub, bus.Done, bus.Step};
        chk(tag, obs, exp);
        drivers = $countones({bus.Rout, bus.DINout, bus.Gout});
        chk({tag, "_bus"}, 32'(drivers <= 1), 32'd1);
    endtask

    localparam logic [31:0] IDLE = 32'd0;

    initial begin
        bus.Run = 1'b0;
        bus.DIN = 16'd0;

        // 1: reset in the middle of add R2,R3.
        cyc("rst0",      1'b1, 1'b0, 16'd0, IDLE);
        cyc("add_t0",    1'b0, 1'b1, din_of(9'b010_010_011), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("add_t1",    1'b0, 1'b0, 16'd0, ew(8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 0, 2'd1));
        cyc("rst_mid1",  1'b1, 1'b0, 16'd0, IDLE);
        cyc("rst_mid2",  1'b1, 1'b0, 16'd0, IDLE);
        cyc("post_rst",  1'b0, 1'b0, 16'd0, IDLE);
        chk("ir_after_rst", 32'(dut.ir_reg), 32'd0);

        // 2: mvi R1,#0x00A5
        cyc("mvi_t0",    1'b0, 1'b1, din_of(9'b001_001_000), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mvi_t1",    1'b0, 1'b0, 16'h00A5, ew(8'h02, 8'h00, 0, 1, 0, 0, 0, 0, 1, 2'd1));
        cyc("mvi_back",  1'b0, 1'b0, 16'd0, IDLE);

        // 3: mv R5,R1
        cyc("mv_t0",     1'b0, 1'b1, din_of(9'b000_101_001), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mv_t1",     1'b0, 1'b0, 16'd0, ew(8'h20, 8'h02, 0, 0, 0, 0, 0, 0, 1, 2'd1));

        // 4: sub R5,R2
        cyc("sub_t0",    1'b0, 1'b1, din_of(9'b011_101_010), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("sub_t1",    1'b0, 1'b0, 16'd0, ew(8'h00, 8'h20, 0, 0, 0, 1, 0, 0, 0, 2'd1));
        cyc("sub_t2",    1'b0, 1'b0, 16'd0, ew(8'h00, 8'h04, 0, 0, 0, 0, 1, 1, 0, 2'd2));
        cyc("sub_t3",    1'b0, 1'b0, 16'd0, ew(8'h20, 8'h00, 0, 0, 1, 0, 0, 0, 1, 2'd3));
        cyc("sub_back",  1'b0, 1'b0, 16'd0, IDLE);

        // 5: Run held high through mvi R0, add R1,R0 and mv R2,R1, with a Run=0 blip in T2.
        cyc("b2b_c1",    1'b0, 1'b1, din_of(9'b001_000_000), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("b2b_c2",    1'b0, 1'b1, 16'h1234, ew(8'h01, 8'h00, 0, 1, 0, 0, 0, 0, 1, 2'd1));
        cyc("b2b_c3",    1'b0, 1'b1, din_of(9'b010_001_000), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("b2b_c4",    1'b0, 1'b1, 16'hFFFF, ew(8'h00, 8'h02, 0, 0, 0, 1, 0, 0, 0, 2'd1));
        cyc("b2b_c5",    1'b0, 1'b0, 16'hFFFF, ew(8'h00, 8'h01, 0, 0, 0, 0, 1, 0, 0, 2'd2));
        cyc("b2b_c6",    1'b0, 1'b1, 16'hFFFF, ew(8'h02, 8'h00, 0, 0, 1, 0, 0, 0, 1, 2'd3));
        cyc("b2b_c7",    1'b0, 1'b1, din_of(9'b000_010_001), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("b2b_c8",    1'b0, 1'b0, 16'd0, ew(8'h04, 8'h02, 0, 0, 0, 0, 0, 0, 1, 2'd1));
        cyc("b2b_idle",  1'b0, 1'b0, 16'd0, IDLE);

        // 6: reserved opcode retires as a NOP.
        cyc("rsv_t0",    1'b0, 1'b1, din_of(9'b110_011_100), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("rsv_t1",    1'b0, 1'b0, 16'd0, ew(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2'd1));
        cyc("rsv_back",  1'b0, 1'b0, 16'd0, IDLE);

        // mv R3,R3 and add R2,R2 with X==Y.
        cyc("mvxx_t0",   1'b0, 1'b1, din_of(9'b000_011_011), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("mvxx_t1",   1'b0, 1'b0, 16'd0, ew(8'h08, 8'h08, 0, 0, 0, 0, 0, 0, 1, 2'd1));
        cyc("addxx_t0",  1'b0, 1'b1, din_of(9'b010_010_010), ew(8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2'd0));
        cyc("addxx_t1",  1'b0, 1'b0, 16'd0, ew(8'h00, 8'h04, 0, 0, 0, 1, 0, 0, 0, 2'd1));
        cyc("addxx_t2",  1'b0, 1'b0, 16'd0, ew(8'h00, 8'h04, 0, 0, 0, 0, 1, 0, 0, 2'd2));
        cyc("addxx_t3",  1'b0, 1'b0, 16'd0, ew(8'h04, 8'h00, 0, 0, 1, 0, 0, 0, 1, 2'd3));
        cyc("final",     1'b0, 1'b0, 16'd0, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
